witf_scoreboard: RTL
====================

Name: witf_scoreboard

Overview:
- Write-in-flight table (witf) for the in-order NPC pipeline: an ordered FIFO of destination registers dispatched by the IDU and not yet written back.
- Gives the IDU its RAW-hazard stall (isRAW) and back-pressure (witf_full).
- Retires entries in program order when the WBU commits a register write.
- Sits between IDU dispatch and WBU register-file write; it is the stall scheduler for the decode stage.

Parameters:
- DEPTH, 4, number of in-flight entries; power of two, ≥2.
- PTR_W, 2, log2(DEPTH), FIFO pointer width.
- REG_AW, 5, register index width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-low reset; sampled on clk rising edge.
- disp_en  in  1  IDU dispatches a register-writing instruction (rd≠0) this cycle.
- disp_rd  in  REG_AW  destination register of the dispatched instruction.
- rs1  in  REG_AW  source 1 index of the instruction currently in ID.
- rs2  in  REG_AW  source 2 index of the instruction currently in ID.
- wb_en  in  1  WBU writes a register with rd≠0 this cycle (retire).
- wb_rd  in  REG_AW  register being written back.
- isRAW  out  1  ID instruction reads a register still pending in the table.
- witf_full  out  1  table holds DEPTH entries.
- witf_empty  out  1  table holds 0 entries.
- witf_cnt  out  PTR_W+1  current occupancy, 0..DEPTH.
- witf_err  out  1  sticky protocol error: overflow, underflow or retire-order mismatch.

Behaviour:
- State:
  - DEPTH entries of {valid, rd}.
  - head pointer (oldest) and tail pointer (next free), each PTR_W bits, wrapping modulo DEPTH.
  - count, PTR_W+1 bits.
  - err flag.
- Reset (rst=0 at clk edge): all valid=0, head=tail=0, count=0, err=0.
  - Outputs after reset: witf_empty=1, witf_full=0, witf_cnt=0, isRAW=0, witf_err=0.
  - Reset wins over every same-cycle disp/wb.
- Dispatch (disp_en=1, table not full):
  - entry[tail] ← {1, disp_rd}; tail ← tail+1.
  - New entry affects isRAW from the next cycle.
- Retire (wb_en=1, table not empty):
  - entry[head].valid ← 0; head ← head+1.
  - If wb_rd ≠ entry[head].rd, set err; the entry is still popped.
- Simultaneous dispatch and retire, table neither empty nor full: both happen; count unchanged.
- Simultaneous dispatch and retire, table full: retire happens; dispatch is dropped and err set. IDU never dispatches while witf_full=1.
- Simultaneous dispatch and retire, table empty: dispatch happens; retire is an underflow and sets err.
- count: +1 on accepted dispatch, −1 on accepted retire, unchanged when both or neither.
- Overflow: disp_en while full and no retire → ignored, err ← 1.
- Underflow: wb_en while empty → ignored, err ← 1.
- err is sticky until reset.
- isRAW (combinational):
  - OR over valid entries of ((entry.rd==rs1 && rs1≠0) || (entry.rd==rs2 && rs2≠0)).
  - An entry being retired this cycle still counts; the register file updates at this edge and there is no bypass. Hazard clears the following cycle.
  - rs1/rs2 are always checked, even for formats that do not use them (conservative).
- witf_full = (count==DEPTH); witf_empty = (count==0); witf_cnt = count. All registered-state derived, no input paths.
- Duplicate rd across entries is legal (WAW). isRAW stays high until the last matching entry retires.
- pipeline_flush is not an input. Dispatched instructions always reach WB in order; flush only suppresses disp_en in the IDU.
- Pointer wrap: head/tail roll DEPTH−1→0 without a bubble.

Test Plan:
- Reset → witf_empty=1, witf_cnt=0, isRAW=0, witf_err=0. Dispatch rd=5 and pulse rst=0 in the same cycle → table still empty afterwards.
- Dispatch rd=5; next cycle rs1=5 → isRAW=1. Retire wb_rd=5 → isRAW=1 that cycle, 0 next cycle. rs1=0 with entry rd=0 never forced → isRAW=0.
- Dispatch rd=1,2,3,4 on consecutive cycles → witf_full=1, witf_cnt=4. Extra disp_en → ignored, witf_err=1.
- Full table: disp rd=7 with retire wb_rd=1 in the same cycle → dispatch dropped, witf_cnt=3, witf_err=1.
- Non-full table: simultaneous disp rd=9 / retire → witf_cnt unchanged.
- Eight dispatch+retire pairs with rd=1..8 → pointers wrap, witf_cnt stays 1, in-order retire, witf_err=0.
- Dispatch rd=3 then rd=3 (WAW); first retire → rs2=3 still isRAW=1; second retire → isRAW=0.
- Protocol violations on an empty table: wb_en=1 → witf_err=1, witf_cnt=0. Dispatch rd=4 then retire wb_rd=6 → witf_err=1, witf_empty=1.

Source files
------------

// File: rtl/witf_scoreboard.sv
// witf_scoreboard -- write-in-flight table for the in-order pipeline.
//
// Ordered FIFO of destination registers that the decode stage has dispatched
// and the writeback stage has not yet committed. Decode uses it to detect
// read-after-write hazards (isRAW) and to stall when the table is full.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-low reset
//   disp_en    decode dispatches a register-writing instruction
//   disp_rd    destination register of that instruction
//   rs1, rs2   source indices of the instruction currently in decode
//   wb_en      writeback commits a register write (retire oldest entry)
//   wb_rd      register being written back
//   isRAW      decode instruction reads a register still in flight
//   witf_full  table holds DEPTH entries
//   witf_empty table holds no entries
//   witf_cnt   occupancy, 0..DEPTH
//   witf_err   sticky protocol error (overflow, underflow, out-of-order retire)
module witf_scoreboard #(
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_en,
  input  logic [REG_AW-1:0] disp_rd,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_rd,
  output logic              isRAW,
  output logic              witf_full,
  output logic              witf_empty,
  output logic [PTR_W:0]    witf_cnt,
  output logic              witf_err
);

  localparam logic [PTR_W:0] FULL_CNT = PTR_W'(1) << PTR_W;

  logic [DEPTH-1:0]  valid_reg;
  logic [REG_AW-1:0] rd_mem [DEPTH];
  logic [PTR_W-1:0]  head_reg;
  logic [PTR_W-1:0]  tail_reg;
  logic [PTR_W:0]    count_reg;
  logic              err_reg;

  logic              full;
  logic              empty;
  logic              do_disp;
  logic              do_retire;
  logic              order_bad;
  logic [DEPTH-1:0]  hit;

  assign full  = (count_reg == FULL_CNT);
  assign empty = (count_reg == '0);

  // Full/empty checks use the state before this edge: a retire on a full
  // table does not make room for a same-cycle dispatch, and a dispatch into
  // an empty table does not give a same-cycle retire anything to pop.
  // Because of this, head and tail never address the same entry in a cycle
  // where both a push and a pop happen.
  assign do_disp   = disp_en && !full;
  assign do_retire = wb_en && !empty;
  assign order_bad = do_retire && (wb_rd != rd_mem[head_reg]);

  // Per-entry hazard match. Index 0 is hardwired and never a hazard, so a
  // zero source index is excluded even if a zero rd ever lands in the table.
  // An entry retiring this cycle is still valid here: the register file is
  // written at this edge with no bypass, so the hazard clears next cycle.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_hit
      assign hit[gi] = valid_reg[gi] &&
                       (((rd_mem[gi] == rs1) && (rs1 != '0)) ||
                        ((rd_mem[gi] == rs2) && (rs2 != '0)));
    end
  endgenerate

  assign isRAW      = |hit;
  assign witf_full  = full;
  assign witf_empty = empty;
  assign witf_cnt   = count_reg;
  assign witf_err   = err_reg;

  // Register indices carry no reset; valid bits alone define occupancy.
  always_ff @(posedge clk) begin
    if (do_disp) begin
      rd_mem[tail_reg] <= disp_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_reg <= '0;
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      if (do_retire) begin
        valid_reg[head_reg] <= 1'b0;
        head_reg            <= head_reg + 1'b1;
      end
      if (do_disp) begin
        valid_reg[tail_reg] <= 1'b1;
        tail_reg            <= tail_reg + 1'b1;
      end
      case ({do_disp, do_retire})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      // Overflow, underflow and a mismatched retire are all sticky.
      if ((disp_en && full) || (wb_en && empty) || order_bad) begin
        err_reg <= 1'b1;
      end
    end
  end

endmodule
